rr_arb4: RTL

//  Four-requester round-robin arbiter that shares one downstream port (valid/ready) between four upstream sources.

---
 rtl/rr_arb_pkg.sv | 12 +
 rtl/rr_arb4_mux4.sv | 22 ++
 rtl/rr_arb4.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and sizing for the four-way round-robin arbiter.
package rr_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    localparam int ARB_N = 4;
    localparam int SEL_W = 2;

endpackage

// File: rtl/rr_arb4_mux4.sv
// Four-input payload multiplexer steered by the arbiter's registered grant index.
module rr_arb4_mux4 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            sel,
    input  logic [DATA_WIDTH-1:0] d0,
    input  logic [DATA_WIDTH-1:0] d1,
    input  logic [DATA_WIDTH-1:0] d2,
    input  logic [DATA_WIDTH-1:0] d3,
    output logic [DATA_WIDTH-1:0] y
);

    always_comb begin
        unique case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter in front of one valid/ready port.
// Optional back-pressure counter (stall_cnt) is built when RR_ARB_STALL_CNT_EN is defined.
module rr_arb4
    import rr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ARB_N-1:0]      req_valid,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    input  logic [DATA_WIDTH-1:0] req_data2,
    input  logic [DATA_WIDTH-1:0] req_data3,
    output logic [ARB_N-1:0]      req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]      out_sel
`ifdef RR_ARB_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    arb_state_t       state, state_nxt;
    logic             out_valid_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [SEL_W-1:0] last, last_nxt;
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] winner;
    logic             handshake;
    logic             any_valid;

    // Rotate so the requester after 'base' sits at bit 0, take the lowest set bit, rotate back.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [ARB_N-1:0] valid,
                                                 input logic [SEL_W-1:0] base_idx);
        logic [SEL_W-1:0] start;
        logic [ARB_N-1:0] rot;
        logic [SEL_W-1:0] idx;
        start = base_idx + SEL_W'(1);
        rot   = ARB_N'({valid, valid} >> start);
        idx   = '0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (rot[i]) idx = SEL_W'(i);
        end
        return idx + start;
    endfunction

    assign handshake = out_valid & out_ready;
    assign any_valid = |req_valid;
    // While busy the grant being retired becomes the new 'last' on this same edge.
    assign base      = (state == ARB_BUSY) ? out_sel : last;
    assign winner    = rr_pick(req_valid, base);
    assign req_ready = handshake ? (ARB_N'(1) << out_sel) : '0;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt     = state;
        out_valid_nxt = out_valid;
        sel_nxt       = out_sel;
        last_nxt      = last;
        unique case (state)
            ARB_IDLE: begin
                if (any_valid) begin
                    state_nxt     = ARB_BUSY;
                    out_valid_nxt = 1'b1;
                    sel_nxt       = winner;
                end
            end
            ARB_BUSY: begin
                if (handshake) begin
                    last_nxt = out_sel;
                    if (any_valid) begin
                        sel_nxt = winner;
                    end else begin
                        state_nxt     = ARB_IDLE;
                        out_valid_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            out_valid <= 1'b0;
            out_sel   <= '0;
            last      <= SEL_W'(ARB_N - 1);
        end else begin
            state     <= state_nxt;
            out_valid <= out_valid_nxt;
            out_sel   <= sel_nxt;
            last      <= last_nxt;
        end
    end

`ifdef RR_ARB_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    rr_arb4_mux4 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mux4 (
        .sel(out_sel),
        .d0 (req_data0),
        .d1 (req_data1),
        .d2 (req_data2),
        .d3 (req_data3),
        .y  (out_data)
    );

endmodule
